// File: rtl/isq_issue_arbiter.sv
// Oldest-first issue arbiter with starvation override, feeding a single-entry issue register.
// Latency req->iss 1 cycle; stalls grants while the held packet is blocked or a flush is active.
module isq_issue_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 248,
  parameter int ROBID_W      = 7,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          iss_valid,
  output logic [DATA_WIDTH-1:0]         iss_data,
  output logic [$clog2(NUM_REQ)-1:0]    iss_src,
  input  logic                          iss_ready,
  input  logic                          flush_valid,
  input  logic [ROBID_W-1:0]            flush_robid
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // The MSB is the wrap bit; when wrap bits differ the index ordering inverts.
  function automatic logic older(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
    if (a[ROBID_W-1] == b[ROBID_W-1]) return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    else                              return a[ROBID_W-2:0] > b[ROBID_W-2:0];
  endfunction

  logic                  iss_valid_q, iss_valid_d;
  logic [DATA_WIDTH-1:0] iss_data_q,  iss_data_d;
  logic [SEL_W-1:0]      iss_src_q,   iss_src_d;
  logic [CNT_W-1:0]      cnt_q [NUM_REQ];
  logic [CNT_W-1:0]      cnt_d [NUM_REQ];

  logic [ROBID_W-1:0]    robid [NUM_REQ];
  logic [ROBID_W-1:0]    best_robid;
  logic [ROBID_W-1:0]    iss_robid;
  logic [SEL_W-1:0]      starve_sel, age_sel, sel;
  logic                  starve_found, age_found;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  load_en, grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      robid[i] = req_data[i*DATA_WIDTH + DATA_WIDTH - 1 -: ROBID_W];
    end
  end

  assign iss_robid = iss_data_q[DATA_WIDTH-1 -: ROBID_W];

  // Scanning upward and replacing only on strictly older keeps ties at the lowest index.
  always_comb begin
    starve_found = 1'b0;
    starve_sel   = '0;
    age_found    = 1'b0;
    age_sel      = '0;
    best_robid   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && cnt_q[i] == LIMIT && !starve_found) begin
        starve_found = 1'b1;
        starve_sel   = SEL_W'(i);
      end
      if (req_valid[i] && (!age_found || older(robid[i], best_robid))) begin
        age_found  = 1'b1;
        age_sel    = SEL_W'(i);
        best_robid = robid[i];
      end
    end
    sel = starve_found ? starve_sel : age_sel;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (SEL_W'(i) == sel) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign load_en   = !reset && !flush_valid && (!iss_valid_q || iss_ready);
  assign grant     = load_en && (|req_valid);
  assign req_ready = grant ? (NUM_REQ'(1) << sel) : '0;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_data_d  = iss_data_q;
    iss_src_d   = iss_src_q;
    for (int i = 0; i < NUM_REQ; i++) cnt_d[i] = cnt_q[i];

    if (grant) begin
      iss_valid_d = 1'b1;
      iss_data_d  = sel_data;
      iss_src_d   = sel;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (SEL_W'(i) == sel)           cnt_d[i] = '0;
        else if (req_valid[i])          cnt_d[i] = (cnt_q[i] == LIMIT) ? LIMIT : cnt_q[i] + CNT_W'(1);
        else                            cnt_d[i] = '0;
      end
    end else if (flush_valid && iss_valid_q && older(flush_robid, iss_robid)) begin
      // Squash wins even if the FU accepts this cycle; the FU ignores it under flush.
      iss_valid_d = 1'b0;
    end else if (iss_valid_q && iss_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      iss_data_q  <= '0;
      iss_src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_data_q  <= iss_data_d;
      iss_src_q   <= iss_src_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_data  = iss_data_q;
  assign iss_src   = iss_src_q;

endmodule

// File: tb/tb_isq_issue_arbiter.sv
// Directed bench for isq_issue_arbiter: reset, age pick with wrap, backpressure, starvation, flush.
module tb_isq_issue_arbiter;

  logic         clock;
  logic         reset;
  logic [1:0]   req_valid;
  logic [495:0] req_data;
  logic [1:0]   req_ready;
  logic         iss_valid;
  logic [247:0] iss_data;
  logic [0:0]   iss_src;
  logic         iss_ready;
  logic         flush_valid;
  logic [6:0]   flush_robid;

  logic [247:0] d0, d1;
  int checks = 0;
  int errors = 0;

  isq_issue_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(248), .ROBID_W(7), .STARVE_LIMIT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_data(iss_data), .iss_src(iss_src),
    .iss_ready(iss_ready),
    .flush_valid(flush_valid), .flush_robid(flush_robid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [247:0] pkt(input logic [6:0] rid, input logic [15:0] tag);
    return {rid, {225{1'b0}}, tag};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [247:0] p0, input logic [247:0] p1);
    req_valid = v;
    d0 = p0;
    d1 = p1;
    req_data = {p1, p0};
  endtask

  // Advance one edge and settle so registered outputs can be sampled.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    iss_ready = 1'b0;
    flush_valid = 1'b0;
    flush_robid = '0;
    drive(2'b11, pkt(7'h05, 16'h0A0A), pkt(7'h03, 16'h0B0B));

    // T1 reset
    repeat (3) begin
      step();
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_iss_valid", iss_valid, 1'b0);
      chk("rst_iss_data", iss_data, '0);
    end
    reset = 1'b0;
    drive(2'b00, d0, d1);
    #1;
    chk("rel_req_ready", req_ready, 2'b00);
    step();
    chk("rel_iss_valid", iss_valid, 1'b0);

    // T2 age pick, then wrap-bit pick
    iss_ready = 1'b1;
    drive(2'b11, pkt(7'h05, 16'h0A0A), pkt(7'h03, 16'h0B0B));
    #1;
    chk("age_req_ready", req_ready, 2'b10);
    step();
    chk("age_iss_valid", iss_valid, 1'b1);
    chk("age_iss_src", iss_src, 1'b1);
    chk("age_iss_data", iss_data, pkt(7'h03, 16'h0B0B));
    drive(2'b11, pkt(7'h7E, 16'h1111), pkt(7'h02, 16'h2222));
    #1;
    chk("wrap_req_ready", req_ready, 2'b01);
    step();
    chk("wrap_iss_src", iss_src, 1'b0);
    chk("wrap_iss_data", iss_data, pkt(7'h7E, 16'h1111));

    // T3 backpressure, then back-to-back accept+grant
    iss_ready = 1'b0;
    drive(2'b11, pkt(7'h08, 16'h0C0C), pkt(7'h09, 16'h0D0D));
    #1;
    chk("bp_req_ready0", req_ready, 2'b00);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_req_ready", req_ready, 2'b00);
      chk("bp_iss_data", iss_data, pkt(7'h7E, 16'h1111));
      chk("bp_iss_valid", iss_valid, 1'b1);
    end
    iss_ready = 1'b1;
    #1;
    chk("b2b_req_ready", req_ready, 2'b01);
    step();
    chk("b2b_iss_valid", iss_valid, 1'b1);
    chk("b2b_iss_data", iss_data, pkt(7'h08, 16'h0C0C));

    // Mid-operation reset discards the held packet
    reset = 1'b1;
    step();
    chk("mrst_iss_valid", iss_valid, 1'b0);
    chk("mrst_iss_data", iss_data, '0);
    chk("mrst_iss_src", iss_src, 1'b0);
    chk("mrst_req_ready", req_ready, 2'b00);
    reset = 1'b0;

    // T4 starvation: req1 forced on the 9th grant, then req0 again
    drive(2'b11, pkt(7'h01, 16'h00E0), pkt(7'h02, 16'h00E1));
    for (int g = 1; g <= 10; g++) begin
      #1;
      chk($sformatf("starve_req_ready_%0d", g), req_ready, (g == 9) ? 2'b10 : 2'b01);
      step();
      chk($sformatf("starve_iss_src_%0d", g), iss_src, (g == 9) ? 1'b1 : 1'b0);
    end

    // T5 flush: younger held packet squashed even with iss_ready=1
    drive(2'b01, pkt(7'h10, 16'h0E0E), d1);
    #1;
    chk("fl_load_req_ready", req_ready, 2'b01);
    step();
    chk("fl_load_iss_data", iss_data, pkt(7'h10, 16'h0E0E));
    flush_valid = 1'b1;
    flush_robid = 7'h0C;
    drive(2'b11, pkt(7'h11, 16'h0F0F), pkt(7'h12, 16'h0F1F));
    #1;
    chk("fl_req_ready", req_ready, 2'b00);
    step();
    chk("fl_squash_iss_valid", iss_valid, 1'b0);

    // Older held packet survives the flush, then leaves when accepted
    flush_valid = 1'b0;
    iss_ready = 1'b0;
    drive(2'b01, pkt(7'h0A, 16'h0F0A), d1);
    #1;
    chk("fl2_load_req_ready", req_ready, 2'b01);
    step();
    chk("fl2_load_iss_data", iss_data, pkt(7'h0A, 16'h0F0A));
    flush_valid = 1'b1;
    flush_robid = 7'h0C;
    drive(2'b00, d0, d1);
    step();
    chk("fl2_keep_iss_valid", iss_valid, 1'b1);
    chk("fl2_keep_iss_data", iss_data, pkt(7'h0A, 16'h0F0A));
    iss_ready = 1'b1;
    drive(2'b11, pkt(7'h0B, 16'h1B1B), pkt(7'h0B, 16'h2B2B));
    #1;
    chk("fl2_acc_req_ready", req_ready, 2'b00);
    step();
    chk("fl2_acc_iss_valid", iss_valid, 1'b0);

    // Equal robids tie to the lowest index
    flush_valid = 1'b0;
    drive(2'b11, pkt(7'h20, 16'h3030), pkt(7'h20, 16'h3131));
    #1;
    chk("tie_req_ready", req_ready, 2'b01);
    step();
    chk("tie_iss_data", iss_data, pkt(7'h20, 16'h3030));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
